// File: rtl/gated_incr_pkg.sv
// gated_incr_pkg: shared mode encoding, op-select helper and width constants for gated_incr_bank
package gated_incr_pkg;
  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_ACCUM = 2'b01,
    MODE_INCR  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;
  localparam int CARRY_W = 1;
  function automatic logic is_update(mode_e m);
    return m != MODE_HOLD;
  endfunction
endpackage

// File: rtl/gated_incr_chan.sv
// gated_incr_chan: one channel (adder, wrap or clamp via GATED_INCR_SAT_EN, out/vld/ovf registers); ports clk, rst, en, clr, mode, in -> out, vld, ovf
module gated_incr_chan import gated_incr_pkg::*; #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  mode_e            mode,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             vld,
  output logic             ovf
);
  localparam int SW = OUT_W + CARRY_W;
  logic [SW-1:0]    sum;
  logic [OUT_W-1:0] nxt;
  always_comb begin
    sum = mode == MODE_LOAD  ? SW'(in) + SW'(STEP) :
          mode == MODE_ACCUM ? SW'(out) + SW'(in) :
                               SW'(out) + SW'(STEP);
`ifdef GATED_INCR_SAT_EN
    nxt = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`else
    nxt = sum[OUT_W-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out <= '0;
      vld <= 1'b0;
      ovf <= 1'b0;
    end else if (en && is_update(mode)) begin
      out <= nxt;
      vld <= 1'b1;
      ovf <= ovf | sum[OUT_W];
    end else begin
      vld <= 1'b0;
    end
  end
endmodule

// File: rtl/gated_incr_bank.sv
// gated_incr_bank: NCH enable-gated load/accumulate/increment channels plus global update counter (GATED_INCR_SAT_EN selects clamp); ports clk, rst, en, clr, mode, in -> out, vld, ovf, upd_cnt
module gated_incr_bank import gated_incr_pkg::*; #(
  parameter int NCH   = 4,
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       clr,
  input  logic [1:0]           mode,
  input  logic [NCH*IN_W-1:0]  in,
  output logic [NCH*OUT_W-1:0] out,
  output logic [NCH-1:0]       vld,
  output logic [NCH-1:0]       ovf,
  output logic [CNT_W-1:0]     upd_cnt
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gated_incr_chan #(.IN_W(IN_W), .OUT_W(OUT_W), .STEP(STEP)) u_chan (
      .clk (clk),
      .rst (rst),
      .en  (en[i]),
      .clr (clr[i]),
      .mode(mode_e'(mode)),
      .in  (in[i*IN_W +: IN_W]),
      .out (out[i*OUT_W +: OUT_W]),
      .vld (vld[i]),
      .ovf (ovf[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) upd_cnt <= '0;
    else if (|vld) upd_cnt <= upd_cnt + CNT_W'(1);
  end
endmodule
